boot_controller: RTL and testbench

Session controller for the 9-bit processor and its single-port program SRAM. It holds the processor in reset while a host streams a program image into SRAM from address 0. It then releases reset and asserts Run. It watches the processor's store port for a write to the halt address, which ends the session with a captured exit code and an elapsed-cycle count. It sits between the processor's ADDR/DOUT/W/Run/Resetn pins, the SRAM, and the host loader interface.

---
 rtl/boot_controller.sv | 143 ++++++++++++++
 tb/tb_boot_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_controller.sv
// boot_controller
// Session controller between a host program loader, a single-port program
// SRAM and the 9-bit processor. It holds the processor in reset while the
// host streams an image into SRAM from address 0, then releases reset and
// raises Run. A processor store to HALT_ADDR ends the session. The store
// data becomes the exit code and the elapsed RUN-cycle count is kept.
//
// Ports:
//   Clock, Resetn          system clock; synchronous active-low reset
//   start, abort           host session control
//   ld_valid/ld_data/ld_last/ld_ready
//                          host image stream
//   cpu_resetn, cpu_run    to processor Resetn / Run
//   cpu_addr, cpu_dout, cpu_w
//                          processor store port
//   mem_addr, mem_din, mem_we
//                          SRAM port, combinational, zero added latency
//   busy, halted, exit_code, load_err, cycles
//                          session status
//   state_dbg              current FSM state, for observation only
//
// Handshake: a load word transfers on a posedge where ld_valid && ld_ready.
// ld_ready depends only on the state register. It never depends on
// ld_valid, so the host may hold ld_valid/ld_data/ld_last stable until
// the transfer.
module boot_controller #(
  parameter int             N         = 9,
  parameter logic [N-1:0]   HALT_ADDR = 9'h1FF,
  parameter int             CYC_W     = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             ld_valid,
  input  logic [N-1:0]     ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_resetn,
  output logic             cpu_run,
  input  logic [N-1:0]     cpu_addr,
  input  logic [N-1:0]     cpu_dout,
  input  logic             cpu_w,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_din,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [N-1:0]     exit_code,
  output logic             load_err,
  output logic [CYC_W-1:0] cycles,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  // Last address an image word may occupy. HALT_ADDR itself is reserved.
  localparam logic [N-1:0] LAST_ADDR = HALT_ADDR - N'(1);

  logic [2:0]   state;
  logic [2:0]   state_next;
  logic [N-1:0] ptr;
  logic         accept;
  logic         halt_store;
  logic         enter_load;

  assign accept     = (state == S_LOAD) && ld_valid;
  assign halt_store = (state == S_RUN) && cpu_w && (cpu_addr == HALT_ADDR);
  assign enter_load = (state != S_LOAD) && (state_next == S_LOAD);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (ld_last)               state_next = S_RELEASE;
          else if (ptr == LAST_ADDR) state_next = S_IDLE;
        end
      end
      S_RELEASE: state_next = S_RUN;
      S_RUN: begin
        if (halt_store || abort) state_next = S_HALTED;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cpu_resetn <= 1'b0;
      exit_code  <= '0;
      load_err   <= 1'b0;
      cycles     <= '0;
    end else begin
      state <= state_next;
      // Registered so the processor sees a clean edge. The processor leaves
      // reset on entry to RELEASE and stays out of reset through HALTED.
      cpu_resetn <= (state_next == S_RELEASE) || (state_next == S_RUN) ||
                    (state_next == S_HALTED);
      if (enter_load) begin
        ptr       <= '0;
        cycles    <= '0;
        exit_code <= '0;
        load_err  <= 1'b0;
      end else begin
        if (accept) begin
          ptr <= ptr + N'(1);
          if (!ld_last && (ptr == LAST_ADDR)) load_err <= 1'b1;
        end
        if (state == S_RUN) begin
          if (cycles != '1) cycles <= cycles + CYC_W'(1);
          // When a halt store and abort arrive together, the halt store
          // takes priority and its data is kept.
          if (halt_store)  exit_code <= cpu_dout;
          else if (abort)  exit_code <= '0;
        end
      end
    end
  end

  assign ld_ready  = (state == S_LOAD);
  assign cpu_run   = (state == S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
  assign halted    = (state == S_HALTED);
  assign state_dbg = state;

  // The SRAM belongs to the loader during LOAD and to the processor
  // otherwise. The halt store is kept out of memory.
  assign mem_addr = (state == S_LOAD) ? ptr     : cpu_addr;
  assign mem_din  = (state == S_LOAD) ? ld_data : cpu_dout;
  assign mem_we   = accept ||
                    ((state == S_RUN) && cpu_w && (cpu_addr != HALT_ADDR));

endmodule

// File: tb/tb_boot_controller.sv
module tb_boot_controller;

  localparam int N     = 9;
  localparam int CYC_W = 16;

  logic             clk;
  logic             Resetn;
  logic             start;
  logic             abort;
  logic             ld_valid;
  logic [N-1:0]     ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             cpu_resetn;
  logic             cpu_run;
  logic [N-1:0]     cpu_addr;
  logic [N-1:0]     cpu_dout;
  logic             cpu_w;
  logic [N-1:0]     mem_addr;
  logic [N-1:0]     mem_din;
  logic             mem_we;
  logic             busy;
  logic             halted;
  logic [N-1:0]     exit_code;
  logic             load_err;
  logic [CYC_W-1:0] cycles;
  logic [2:0]       state_dbg;

  boot_controller #(.N(N), .HALT_ADDR(9'h1FF), .CYC_W(CYC_W)) dut (
    .Clock(clk), .Resetn(Resetn), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_resetn(cpu_resetn), .cpu_run(cpu_run),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_w(cpu_w),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .busy(busy), .halted(halted), .exit_code(exit_code),
    .load_err(load_err), .cycles(cycles), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [2*N-1:0]     exp_q[$];       // expected SRAM writes {addr, data}
  logic [N+CYC_W-1:0] exp_halt_q[$];  // expected {exit_code, cycles} at halt
  logic [N-1:0]       ref_mem[512];   // reference SRAM contents
  logic [N-1:0]       sram[512];      // SRAM written by the DUT port
  logic [N-1:0]       img_q[$];
  logic [N-1:0]       ptr_m;
  int                 run_cnt;
  bit                 mon_en = 0;
  bit                 saw_run = 0;
  logic               prev_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (mem_we === 1'b1) sram[mem_addr] <= mem_din;

  // Monitor: pops expectations whenever the DUT presents a write or a halt.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cpu_run === 1'b1) saw_run = 1;
      if (mem_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h we %b, required no write",
                   mem_addr, mem_din, mem_we);
        end else begin
          logic [2*N-1:0] e;
          e = exp_q.pop_front();
          check("sram_write", {mem_addr, mem_din}, e);
        end
      end
      if (halted === 1'b1 && prev_halted !== 1'b1) begin
        if (exp_halt_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_halt: got halted=1, required 0");
        end else begin
          logic [N+CYC_W-1:0] h;
          h = exp_halt_q.pop_front();
          check("halt_exit_cycles", {exit_code, cycles}, h);
        end
      end
      prev_halted = halted;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_resetn"}, cpu_resetn, 0);
    check({tag, "_cpu_run"},    cpu_run,    0);
    check({tag, "_ld_ready"},   ld_ready,   0);
    check({tag, "_halted"},     halted,     0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_exit_code"},  exit_code,  0);
    check({tag, "_load_err"},   load_err,   0);
    check({tag, "_cycles"},     cycles,     0);
    check({tag, "_mem_we"},     mem_we,     0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    ptr_m = '0;
    check("start_ld_ready",  ld_ready,  1);
    check("start_busy",      busy,      1);
    check("start_halted",    halted,    0);
    check("start_exit_code", exit_code, 0);
    check("start_cycles",    cycles,    0);
    check("start_load_err",  load_err,  0);
    check("start_cpu_resetn", cpu_resetn, 0);
  endtask

  // gap < 0 selects random idle gaps of 0..2 cycles between words.
  task automatic load_image(input bit has_last, input int gap);
    for (int i = 0; i < img_q.size(); i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i > 0) repeat (g) tick();
      ld_valid = 1'b1;
      ld_data  = img_q[i];
      ld_last  = has_last && (i == img_q.size() - 1);
      exp_q.push_back({ptr_m, img_q[i]});
      ref_mem[ptr_m] = img_q[i];
      ptr_m = ptr_m + 9'd1;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
    if (has_last) begin
      check("release_cpu_resetn", cpu_resetn, 1);
      check("release_cpu_run",    cpu_run,    0);
      tick();
      check("run_cpu_run",        cpu_run,    1);
      check("run_cpu_resetn",     cpu_resetn, 1);
      run_cnt = 0;
    end
  endtask

  task automatic run_store(input logic [N-1:0] addr, input logic [N-1:0] data, input logic w);
    cpu_addr = addr;
    cpu_dout = data;
    cpu_w    = w;
    if (w) begin
      exp_q.push_back({addr, data});
      ref_mem[addr] = data;
    end
    run_cnt++;
    tick();
    cpu_w = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_store(N'($urandom_range(0, 510)), N'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
  endtask

  // kind 0: halt store, 1: abort only, 2: halt store and abort together
  task automatic finish_run(input int kind, input logic [N-1:0] code);
    logic [N-1:0] exp_code;
    cpu_addr = 9'h1FF;
    cpu_dout = code;
    cpu_w    = (kind != 1);
    abort    = (kind != 0);
    exp_code = (kind == 1) ? 9'h000 : code;
    run_cnt++;
    exp_halt_q.push_back({exp_code, CYC_W'(run_cnt)});
    tick();
    cpu_w = 1'b0;
    abort = 1'b0;
    check("halt_halted",     halted,     1);
    check("halt_cpu_run",    cpu_run,    0);
    check("halt_cpu_resetn", cpu_resetn, 1);
  endtask

  task automatic rand_image(input int len);
    img_q.delete();
    for (int i = 0; i < len; i++) img_q.push_back(N'($urandom_range(0, 511)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = '0;
      sram[i]    = '0;
    end
    Resetn = 1'b0; start = 1'b0; abort = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_w = 1'b0;
    ptr_m = '0; run_cnt = 0;
    repeat (3) tick();
    check_reset_values("por");
    mon_en = 1;
    Resetn = 1'b1;
    tick();

    // Fixed 3-word image with one idle cycle between words, then a plain
    // store and a halt with code 9'h02A.
    do_start();
    img_q = '{9'h040, 9'h005, 9'h1A0};
    load_image(1'b1, 1);
    run_store(9'h010, 9'h033, 1'b1);
    run_random(int'($urandom_range(2, 6)));
    finish_run(0, 9'h02A);
    check("sram_halt_loc", sram[9'h1FF], 0);

    // Restart from HALTED, random image, ended by abort.
    do_start();
    rand_image(int'($urandom_range(1, 8)));
    load_image(1'b1, -1);
    run_random(int'($urandom_range(1, 10)));
    finish_run(1, N'($urandom_range(1, 511)));

    // Halt store and abort in the same cycle; the store data wins.
    do_start();
    rand_image(int'($urandom_range(1, 6)));
    load_image(1'b1, -1);
    run_random(int'($urandom_range(0, 5)));
    finish_run(2, N'($urandom_range(1, 511)));
    do_start();

    // Random sessions.
    for (int s = 0; s < 4; s++) begin
      rand_image(int'($urandom_range(1, 10)));
      load_image(1'b1, -1);
      run_random(int'($urandom_range(0, 12)));
      finish_run(int'($urandom_range(0, 2)), N'($urandom_range(0, 511)));
      repeat (int'($urandom_range(0, 2))) tick();
      do_start();
    end

    // Reset while running.
    rand_image(2);
    load_image(1'b1, 0);
    run_random(3);
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    check_reset_values("mid_run");
    tick();

    // 511 words without ld_last exhaust the address space.
    do_start();
    saw_run = 0;
    rand_image(511);
    load_image(1'b0, 0);
    check("trunc_load_err",   load_err,   1);
    check("trunc_busy",       busy,       0);
    check("trunc_ld_ready",   ld_ready,   0);
    check("trunc_halted",     halted,     0);
    check("trunc_cpu_resetn", cpu_resetn, 0);
    repeat (3) tick();
    check("trunc_never_run",  32'(saw_run), 0);
    check("trunc_err_held",   load_err,   1);
    do_start();
    tick();

    check("write_queue_drained", exp_q.size(), 0);
    check("halt_queue_drained",  exp_halt_q.size(), 0);
    for (int i = 0; i < 512; i++) check($sformatf("sram_%0h", i), sram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
